mp_reg_file: RTL and testbench
==============================

// Module: mp_reg_file
// PURPOSE
//   Parametrised multi-port register file. Serves as the GPR file (NUM_RD=2, NUM_WR=1, ZERO_REG=1)
//   and as storage for branch-predictor tables (WIDTH=2, RESET_VAL=2'b01).
//   Reset is a hardware sweep FSM that writes RESET_VAL into every entry, one entry per cycle.
//   Consumers stall on ready=0.
// PARAMETERS
//   WIDTH      16               data width per entry
//   DEPTH      16               number of entries (>=2)
//   ADDR_WIDTH $clog2(DEPTH)    address width (derived, do not override)
//   NUM_RD     2                read ports (1..4)
//   NUM_WR     1                write ports (1..2)
//   RESET_VAL  '0               value written to every entry by the init sweep
//   ZERO_REG   0                1: entry 0 always reads 0, writes to it are dropped
// PORTS
//   clk      in   1                  clock, rising edge
//   reset    in   1                  synchronous, active-high
//   wr_en    in   NUM_WR             per-port write enable
//   wr_addr  in   NUM_WR*ADDR_WIDTH  write addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   wr_data  in   NUM_WR*WIDTH       write data, port p at [p*WIDTH +: WIDTH]
//   rd_addr  in   NUM_RD*ADDR_WIDTH  read addresses, flattened the same way
//   rd_data  out  NUM_RD*WIDTH       read data, flattened the same way
//   ready    out  1                  1 = init sweep complete, writes accepted
// BEHAVIOUR
//   - Reads are combinational: rd_data[p] = mem[rd_addr[p]].
//   - Writes commit at the rising edge where wr_en=1 and state=RUN; visible from the next cycle.
//   - FSM states: INIT, RUN.
//     - reset=1 at an edge: state<=INIT, sweep_ptr<=0, ready<=0. Holds while reset stays high.
//     - INIT, reset=0: mem[sweep_ptr]<=RESET_VAL, sweep_ptr++.
//       On the edge that writes entry DEPTH-1: state<=RUN, ready<=1.
//     - ready therefore rises DEPTH edges after the first edge with reset low.
//     - RUN is held until the next reset.
//   - Reset in mid-sweep or in RUN restarts the sweep at 0. The memory array has no async
//     reset; it is initialised only by the sweep.
//   - During INIT:
//     - every rd_data port returns RESET_VAL (0 for entry 0 if ZERO_REG);
//     - wr_en is ignored and dropped (not queued).
//   - Write collision (NUM_WR=2, same address, both enabled): the higher port index wins.
//   - ZERO_REG=1: a read of address 0 returns 0 and writes to address 0 are ignored.
//     This also applies during INIT.
//   - Out-of-range address (DEPTH not a power of 2, addr>=DEPTH):
//     - read returns '0;
//     - write is dropped.
//   - Reset value of outputs: ready=0. rd_data follows the INIT rule above.
// CONFIGURATION
//   - Macro REG_FILE_BYPASS_EN. When defined, a read of an address being written in the same
//     cycle (RUN, wr_en=1) returns wr_data combinationally. Collision priority applies;
//     ZERO_REG and range rules still apply.
//   - Without it, the read returns the old contents until the next cycle.
// STRUCTURE
//   - Package reg_file_pkg holds:
//     - typedef enum logic {RF_INIT, RF_RUN} rf_state_t;
//     - localparams RF_MAX_RD=4 and RF_MAX_WR=2, used by parameter range checks;
//     - function rf_clog2_safe, which returns 1 for DEPTH<=2.
//   - Sub-module reg_file_init_fsm holds the state register, sweep_ptr and ready, and
//     outputs sweep_we/sweep_addr.
//   - mp_reg_file holds the array, write arbitration, read muxing and bypass.
// TESTING
//   - DEPTH=16, RESET_VAL=16'hA5A5, reset 1 cycle then released:
//     ready=0 for 16 edges and 1 after the 16th; every read returns 16'hA5A5 throughout.
//   - RUN, write addr 3=16'h1234:
//     rd_addr0=3 in the same cycle returns 16'hA5A5 without bypass and 16'h1234 with
//     REG_FILE_BYPASS_EN; the next cycle returns 16'h1234.
//   - NUM_WR=2, both ports write addr 7 (p0=16'h0001, p1=16'h0002) -> mem[7]=16'h0002.
//   - ZERO_REG=1, write addr 0=16'hFFFF -> rd addr 0 returns 0; reads of other addresses
//     are unaffected.
//   - Reset asserted when sweep_ptr=9, after writing addr 2=16'h5555 in an earlier RUN phase:
//     sweep restarts at 0, ready returns after 16 edges, and addr 2 reads RESET_VAL.
//   - WIDTH=2, RESET_VAL=2'b01 with wr_en held high during INIT -> after ready, all entries
//     read 2'b01 (INIT writes dropped).

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file slice.
package reg_file_pkg;

    typedef enum logic {RF_INIT, RF_RUN} rf_state_t;

    localparam int RF_MAX_RD = 4;
    localparam int RF_MAX_WR = 2;

    // Address width that never collapses to zero bits for tiny tables.
    function automatic int rf_clog2_safe(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/reg_file_init_fsm.sv
// Init sweep controller: walks every entry once after reset, then holds RUN and raises ready.
module reg_file_init_fsm
    import reg_file_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = rf_clog2_safe(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    output rf_state_t             state,
    output logic                  sweep_we,
    output logic [ADDR_WIDTH-1:0] sweep_addr,
    output logic                  ready
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ENTRY = ADDR_WIDTH'(DEPTH - 1);

    rf_state_t             state_next;
    logic [ADDR_WIDTH-1:0] sweep_ptr;
    logic [ADDR_WIDTH-1:0] sweep_ptr_next;
    logic                  ready_next;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RF_INIT;
            sweep_ptr <= '0;
            ready     <= 1'b0;
        end else begin
            state     <= state_next;
            sweep_ptr <= sweep_ptr_next;
            ready     <= ready_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_next     = state;
        sweep_ptr_next = sweep_ptr;
        ready_next     = ready;
        sweep_we       = 1'b0;
        case (state)
            RF_INIT: begin
                sweep_we       = !reset;
                sweep_ptr_next = sweep_ptr + ADDR_WIDTH'(1);
                if (sweep_ptr == LAST_ENTRY) begin
                    state_next     = RF_RUN;
                    ready_next     = 1'b1;
                    sweep_ptr_next = '0;
                end
            end
            RF_RUN: begin
                state_next = RF_RUN;
            end
            default: begin
                state_next = RF_INIT;
            end
        endcase
    end

    assign sweep_addr = sweep_ptr;

endmodule

// File: rtl/mp_reg_file.sv
// Parametrised multi-port register file with hardware init sweep.
// Optional macro REG_FILE_BYPASS_EN forwards same-cycle write data to matching reads.
module mp_reg_file
    import reg_file_pkg::*;
#(
    parameter int                 WIDTH      = 16,
    parameter int                 DEPTH      = 16,
    parameter int                 ADDR_WIDTH = rf_clog2_safe(DEPTH),
    parameter int                 NUM_RD     = 2,
    parameter int                 NUM_WR     = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL  = '0,
    parameter bit                 ZERO_REG   = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WR*WIDTH-1:0]      wr_data,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*WIDTH-1:0]      rd_data,
    output logic                         ready
);

    if (DEPTH < 2) begin : g_bad_depth
        $error("mp_reg_file: DEPTH must be at least 2");
    end
    if (NUM_RD < 1 || NUM_RD > RF_MAX_RD) begin : g_bad_rd
        $error("mp_reg_file: NUM_RD out of range");
    end
    if (NUM_WR < 1 || NUM_WR > RF_MAX_WR) begin : g_bad_wr
        $error("mp_reg_file: NUM_WR out of range");
    end

    rf_state_t             state;
    logic                  sweep_we;
    logic [ADDR_WIDTH-1:0] sweep_addr;

    reg_file_init_fsm #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init_fsm (
        .clk        (clk),
        .reset      (reset),
        .state      (state),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr),
        .ready      (ready)
    );

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset branch; the init sweep is its only initialisation.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[sweep_addr] <= RESET_VAL;
        end else if (state == RF_RUN) begin
            // Later ports overwrite earlier ones, giving the higher index priority on collision.
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_en[p] && in_range(wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]) &&
                    !is_zero_reg(wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    mem[wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data[p*WIDTH +: WIDTH];
                end
            end
        end
    end

    logic [ADDR_WIDTH-1:0] ra;
    logic [WIDTH-1:0]      rv;

    always_comb begin
        rd_data = '0;
        ra      = '0;
        rv      = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            ra = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            rv = '0;
            if (in_range(ra)) begin
                rv = (state == RF_INIT) ? RESET_VAL : mem[ra];
`ifdef REG_FILE_BYPASS_EN
                if (state == RF_RUN) begin
                    for (int q = 0; q < NUM_WR; q++) begin
                        if (wr_en[q] && (wr_addr[q*ADDR_WIDTH +: ADDR_WIDTH] == ra)) begin
                            rv = wr_data[q*WIDTH +: WIDTH];
                        end
                    end
                end
`endif
            end
            if (is_zero_reg(ra)) begin
                rv = '0;
            end
            rd_data[p*WIDTH +: WIDTH] = rv;
        end
    end

endmodule

// File: tb/tb_mp_reg_file.sv
// Scoreboard bench for mp_reg_file: a 2W/2R 16x16 instance and a 1W/1R 12x2 zero-reg instance.
module tb_mp_reg_file;

    localparam logic [15:0] RV_A = 16'hA5A5;
    localparam logic [1:0]  RV_B = 2'b01;
`ifdef REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;

    logic [1:0]  wr_en_a;
    logic [7:0]  wr_addr_a;
    logic [31:0] wr_data_a;
    logic [7:0]  rd_addr_a;
    logic [31:0] rd_data_a;
    logic        ready_a;

    logic [0:0]  wr_en_b;
    logic [3:0]  wr_addr_b;
    logic [1:0]  wr_data_b;
    logic [3:0]  rd_addr_b;
    logic [1:0]  rd_data_b;
    logic        ready_b;

    always #5 clk = ~clk;

    mp_reg_file #(
        .WIDTH     (16),
        .DEPTH     (16),
        .NUM_RD    (2),
        .NUM_WR    (2),
        .RESET_VAL (RV_A),
        .ZERO_REG  (1'b0)
    ) dut_a (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en_a),
        .wr_addr (wr_addr_a),
        .wr_data (wr_data_a),
        .rd_addr (rd_addr_a),
        .rd_data (rd_data_a),
        .ready   (ready_a)
    );

    mp_reg_file #(
        .WIDTH     (2),
        .DEPTH     (12),
        .NUM_RD    (1),
        .NUM_WR    (1),
        .RESET_VAL (RV_B),
        .ZERO_REG  (1'b1)
    ) dut_b (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en_b),
        .wr_addr (wr_addr_b),
        .wr_data (wr_data_b),
        .rd_addr (rd_addr_b),
        .rd_data (rd_data_b),
        .ready   (ready_b)
    );

    typedef enum {S_RDA0, S_RDA1, S_RDB, S_RDYA, S_RDYB} src_t;
    typedef struct {
        string       tag;
        src_t        src;
        logic [15:0] exp;
    } sb_t;

    sb_t         sbq[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [1:0]  model_b [12];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input src_t src, input logic [15:0] exp);
        sb_t e;
        e.tag = tag;
        e.src = src;
        e.exp = exp;
        sbq.push_back(e);
    endtask

    // Outputs are sampled on the falling edge, away from the committing rising edge.
    task automatic drain();
        sb_t         e;
        logic [15:0] obs;
        @(negedge clk);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.src)
                S_RDA0:  obs = rd_data_a[15:0];
                S_RDA1:  obs = rd_data_a[31:16];
                S_RDB:   obs = {14'b0, rd_data_b};
                S_RDYA:  obs = {15'b0, ready_a};
                default: obs = {15'b0, ready_b};
            endcase
            check(e.tag, obs, e.exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_b(input int addr);
        if (addr == 0 || addr >= 12) return 16'h0;
        return {14'b0, model_b[addr]};
    endfunction

    // Called one step after the reset edge; writes are held on during INIT and must be dropped.
    task automatic run_sweep(input string name);
        wr_en_a   = 2'b11;
        wr_addr_a = {4'd5, 4'd4};
        wr_data_a = {16'hDEAD, 16'hDEAD};
        wr_en_b   = 1'b1;
        wr_addr_b = 4'd3;
        wr_data_b = 2'b10;
        for (int k = 0; k <= 16; k++) begin
            rd_addr_a = {4'(15 - k % 16), 4'(k % 16)};
            rd_addr_b = 4'(k % 16);
            push({name, "_ready_a"}, S_RDYA, {15'b0, (k >= 16)});
            push({name, "_ready_b"}, S_RDYB, {15'b0, (k >= 12)});
            push({name, "_rd_a0"}, S_RDA0, RV_A);
            push({name, "_rd_a1"}, S_RDA1, RV_A);
            push({name, "_rd_b"}, S_RDB, exp_b(k % 16));
            drain();
            step();
            if (k + 1 >= 12) wr_en_b = 1'b0;
            if (k + 1 >= 16) wr_en_a = 2'b00;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        wr_en_a   = '0;
        wr_addr_a = '0;
        wr_data_a = '0;
        rd_addr_a = '0;
        wr_en_b   = '0;
        wr_addr_b = '0;
        wr_data_b = '0;
        rd_addr_b = 4'd1;
        for (int i = 0; i < 12; i++) model_b[i] = RV_B;

        step();
        push("rst_ready_a", S_RDYA, 16'h0);
        push("rst_ready_b", S_RDYB, 16'h0);
        push("rst_rd_a0", S_RDA0, RV_A);
        push("rst_rd_b", S_RDB, 16'h0001);
        drain();
        step();
        reset = 1'b0;
        run_sweep("sweep1");

        rd_addr_a = {4'd4, 4'd5};
        push("init_wr_dropped_a5", S_RDA0, RV_A);
        push("init_wr_dropped_a4", S_RDA1, RV_A);
        rd_addr_b = 4'd3;
        push("init_wr_dropped_b3", S_RDB, 16'h0001);
        drain();

        // Single write with same-cycle read of the written address.
        step();
        wr_en_a   = 2'b01;
        wr_addr_a = {4'd0, 4'd3};
        wr_data_a = {16'h0000, 16'h1234};
        rd_addr_a = {4'd6, 4'd3};
        push("same_cycle_rd3", S_RDA0, BYPASS ? 16'h1234 : RV_A);
        push("other_rd6", S_RDA1, RV_A);
        drain();
        step();
        wr_en_a = 2'b00;
        push("next_cycle_rd3", S_RDA0, 16'h1234);
        drain();

        // Both ports hit address 7: port 1 must win.
        step();
        wr_en_a   = 2'b11;
        wr_addr_a = {4'd7, 4'd7};
        wr_data_a = {16'h0002, 16'h0001};
        rd_addr_a = {4'd7, 4'd3};
        push("collide_same_cycle", S_RDA1, BYPASS ? 16'h0002 : RV_A);
        push("rd3_kept", S_RDA0, 16'h1234);
        drain();
        step();
        wr_en_a   = 2'b11;
        wr_addr_a = {4'd9, 4'd10};
        wr_data_a = {16'hBEEF, 16'hCAFE};
        rd_addr_a = {4'd9, 4'd7};
        push("collide_rd7", S_RDA0, 16'h0002);
        drain();
        step();
        wr_en_a   = 2'b00;
        rd_addr_a = {4'd9, 4'd10};
        push("dual_wr_p0", S_RDA0, 16'hCAFE);
        push("dual_wr_p1", S_RDA1, 16'hBEEF);
        drain();

        // Zero register, bypass and range rules on the 12-entry table.
        step();
        wr_en_b   = 1'b1;
        wr_addr_b = 4'd0;
        wr_data_b = 2'b11;
        rd_addr_b = 4'd0;
        push("zero_reg_same_cycle", S_RDB, 16'h0);
        drain();
        step();
        wr_addr_b = 4'd5;
        wr_data_b = 2'b10;
        rd_addr_b = 4'd5;
        push("b_same_cycle_rd5", S_RDB, BYPASS ? 16'h0002 : 16'h0001);
        drain();
        step();
        model_b[5] = 2'b10;
        wr_addr_b  = 4'd14;
        wr_data_b  = 2'b11;
        rd_addr_b  = 4'd14;
        push("oor_same_cycle", S_RDB, 16'h0);
        drain();
        step();
        wr_en_b = 1'b0;
        for (int a = 0; a < 16; a++) begin
            rd_addr_b = 4'(a);
            push($sformatf("b_scan%0d", a), S_RDB, exp_b(a));
            drain();
        end

        // Write in RUN, then reset in mid-sweep at sweep_ptr=9.
        step();
        wr_en_a   = 2'b01;
        wr_addr_a = {4'd0, 4'd2};
        wr_data_a = {16'h0000, 16'h5555};
        step();
        wr_en_a   = 2'b00;
        rd_addr_a = {4'd3, 4'd2};
        push("run_wr2", S_RDA0, 16'h5555);
        drain();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (9) step();
        push("mid_sweep_ready", S_RDYA, 16'h0);
        push("mid_sweep_rd2", S_RDA0, RV_A);
        drain();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) model_b[i] = RV_B;
        run_sweep("sweep2");
        rd_addr_a = {4'd3, 4'd2};
        rd_addr_b = 4'd5;
        push("restart_rd2", S_RDA0, RV_A);
        push("restart_rd3", S_RDA1, RV_A);
        push("restart_b5", S_RDB, 16'h0001);
        drain();

        if (sbq.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_leftover: observed %0d expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
